// File: rtl/gray_pkg.sv
// Shared constants and helpers for the Gray-code sequence generator.
// Provides bin2gray/gray2bin over a fixed 16-bit datapath with width masking.
package gray_pkg;

    localparam int PRESC_W    = 16;
    localparam int GRAY_MAX_W = 16;

    // Masks the result to w bits so narrower counters reuse one function.
    function automatic logic [GRAY_MAX_W-1:0] bin2gray(
        input logic [GRAY_MAX_W-1:0] v,
        input int                    w
    );
        logic [GRAY_MAX_W:0]   m;
        logic [GRAY_MAX_W-1:0] vm;
        m  = (17'd1 << w) - 17'd1;
        vm = v & m[GRAY_MAX_W-1:0];
        return vm ^ (vm >> 1);
    endfunction

    function automatic logic [GRAY_MAX_W-1:0] gray2bin(
        input logic [GRAY_MAX_W-1:0] v
    );
        logic [GRAY_MAX_W-1:0] r;
        r = v;
        for (int i = GRAY_MAX_W - 2; i >= 0; i--) begin
            r[i] = r[i+1] ^ v[i];
        end
        return r;
    endfunction

endpackage

// File: rtl/gray_step_prescaler.sv
// Step prescaler: emits a one-cycle tick every STEP_DIV enabled cycles.
// Ports: clk, rst_n (async low), en (advance), clr (restart), tick (combinational).
module gray_step_prescaler
    import gray_pkg::*;
#(
    parameter int unsigned STEP_DIV = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic clr,
    output logic tick
);

    localparam logic [PRESC_W-1:0] LP_LAST = PRESC_W'(STEP_DIV - 1);

    logic [PRESC_W-1:0] r_cnt;
    logic               w_last;

    assign w_last = (r_cnt == LP_LAST);
    // Tick is seen by the counter on the same edge that wraps the prescaler.
    assign tick   = en & ~clr & w_last;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (clr) begin
            r_cnt <= '0;
        end else if (en) begin
            if (w_last) begin
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + PRESC_W'(1);
            end
        end
    end

endmodule

// File: rtl/gray_sequence_generator.sv
// Up/down binary counter with a same-edge registered Gray image (g == gray(b)).
// Ports: clk, rst_n, en, up_dn, clr, load, load_val -> b, g, step, tc pulses.
module gray_sequence_generator
    import gray_pkg::*;
#(
    parameter int WIDTH    = 4,
    parameter int STEP_DIV = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             up_dn,
    input  logic             clr,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] g,
    output logic             step,
    output logic             tc
);

    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_g;
    logic             r_step;
    logic             r_tc;

    logic             w_tick;
    logic             w_wrap;
    logic [WIDTH-1:0] w_b_next;
    logic [WIDTH-1:0] w_src;
    logic [WIDTH-1:0] w_g_src;

    gray_step_prescaler #(
        .STEP_DIV (STEP_DIV)
    ) u_presc (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (en),
        .clr   (clr | load),
        .tick  (w_tick)
    );

    always_comb begin
        w_b_next = up_dn ? (r_b + WIDTH'(1)) : (r_b - WIDTH'(1));
        w_wrap   = up_dn ? (&r_b) : (~|r_b);
        // Load and step share one Gray encoder; load wins when both apply.
        w_src    = load ? load_val : w_b_next;
        w_g_src  = WIDTH'(bin2gray(GRAY_MAX_W'(w_src), WIDTH));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_b    <= '0;
            r_g    <= '0;
            r_step <= 1'b0;
            r_tc   <= 1'b0;
        end else if (clr) begin
            r_b    <= '0;
            r_g    <= '0;
            r_step <= 1'b0;
            r_tc   <= 1'b0;
        end else if (load) begin
            r_b    <= load_val;
            r_g    <= w_g_src;
            r_step <= 1'b0;
            r_tc   <= 1'b0;
        end else if (w_tick) begin
            r_b    <= w_b_next;
            r_g    <= w_g_src;
            r_step <= 1'b1;
            r_tc   <= w_wrap;
        end else begin
            r_step <= 1'b0;
            r_tc   <= 1'b0;
        end
    end

    assign b    = r_b;
    assign g    = r_g;
    assign step = r_step;
    assign tc   = r_tc;

endmodule
